// File: rtl/btn_debounce_ev_if.sv
// btn_debounce_ev_if: raw button pads in, conditioned level and event pulses out
// btn_in      raw asynchronous pads (driven by master)
// btn_stable  debounced pressed level
// btn_press / btn_release / btn_long / btn_repeat  one-cycle event pulses
interface btn_debounce_ev_if #(parameter int BTN_WIDTH = 8);
    logic [BTN_WIDTH-1:0] btn_in, btn_stable, btn_press, btn_release, btn_long, btn_repeat;
    modport master(output btn_in, input btn_stable, btn_press, btn_release, btn_long, btn_repeat);
    modport slave(input btn_in, output btn_stable, btn_press, btn_release, btn_long, btn_repeat);
endinterface

// File: rtl/btn_debounce_ev.sv
// btn_debounce_ev: per-channel button synchroniser, debounce filter and press/release/long/repeat event generator
// sys_clk  system clock, rising edge
// rst_n    asynchronous active-low reset
// bus      slave side of btn_debounce_ev_if (pads in, level and pulses out)
module btn_debounce_ev #(
    parameter int          BTN_WIDTH     = 8,
    parameter logic [19:0] DEB_CYCLES    = 20'h7_ffff,
    parameter logic [31:0] LONG_CYCLES   = 32'd50_000_000,
    parameter logic [31:0] REPEAT_CYCLES = 32'd10_000_000,
    parameter bit          REPEAT_EN     = 1'b1,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input logic              sys_clk,
    input logic              rst_n,
    btn_debounce_ev_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HELD, RPT} state_t;
    for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_ch
        logic sync0, sync1, pressed_s, stable, acc, rise, fall;
        logic press, rel, long_p, rep_p, long_nx, rep_p_nx;
        logic [19:0] deb_cnt;
        logic [31:0] hold_cnt, hold_nx, rep_cnt, rep_nx;
        state_t state, state_nx;
        assign pressed_s = sync1 ^ ACTIVE_LOW;
        // acc: this edge completes DEB_CYCLES consecutive disagreeing samples
        assign acc  = (pressed_s != stable) && (deb_cnt == DEB_CYCLES - 20'd1);
        assign rise = acc & ~stable;
        assign fall = acc & stable;
        always_ff @(posedge sys_clk or negedge rst_n) begin
            if (!rst_n) begin
                sync0    <= ACTIVE_LOW;
                sync1    <= ACTIVE_LOW;
                deb_cnt  <= '0;
                stable   <= 1'b0;
                press    <= 1'b0;
                rel      <= 1'b0;
                state    <= IDLE;
                hold_cnt <= '0;
                rep_cnt  <= '0;
                long_p   <= 1'b0;
                rep_p    <= 1'b0;
            end else begin
                sync0    <= bus.btn_in[i];
                sync1    <= sync0;
                deb_cnt  <= (pressed_s == stable || acc) ? '0 : deb_cnt + 20'd1;
                stable   <= stable ^ acc;
                press    <= rise;
                rel      <= fall;
                state    <= state_nx;
                hold_cnt <= hold_nx;
                rep_cnt  <= rep_nx;
                long_p   <= long_nx;
                rep_p    <= rep_p_nx;
            end
        end
        // release has priority so no long/repeat pulse lands in the release cycle
        always_comb begin
            state_nx = state;
            hold_nx  = hold_cnt;
            rep_nx   = rep_cnt;
            long_nx  = 1'b0;
            rep_p_nx = 1'b0;
            if (fall) begin
                state_nx = IDLE;
                hold_nx  = '0;
                rep_nx   = '0;
            end else begin
                case (state)
                    IDLE: if (rise) begin
                        state_nx = HELD;
                        hold_nx  = '0;
                    end
                    HELD: if (hold_cnt == LONG_CYCLES - 32'd1) begin
                        state_nx = RPT;
                        long_nx  = 1'b1;
                        hold_nx  = '0;
                        rep_nx   = '0;
                    end else begin
                        hold_nx = hold_cnt + 32'd1;
                    end
                    RPT: if (REPEAT_EN) begin
                        rep_p_nx = rep_cnt == REPEAT_CYCLES - 32'd1;
                        rep_nx   = rep_p_nx ? '0 : rep_cnt + 32'd1;
                    end
                    default: state_nx = IDLE;
                endcase
            end
        end
        assign bus.btn_stable[i]  = stable;
        assign bus.btn_press[i]   = press;
        assign bus.btn_release[i] = rel;
        assign bus.btn_long[i]    = long_p;
        assign bus.btn_repeat[i]  = rep_p;
    end
endmodule

// File: tb/tb_btn_debounce_ev.sv
// tb_btn_debounce_ev: randomized and directed checks of btn_debounce_ev against a window/timestamp reference model
module tb_btn_debounce_ev;
    localparam int W = 8, DEB = 4, LONG = 20, REP = 8;
    logic sys_clk = 1'b0;
    logic rst_n = 1'b0;
    logic [W-1:0] pad = '1;
    always #5 sys_clk = ~sys_clk;
    btn_debounce_ev_if #(.BTN_WIDTH(W)) bus_a ();
    btn_debounce_ev_if #(.BTN_WIDTH(W)) bus_b ();
    assign bus_a.btn_in = pad;
    assign bus_b.btn_in = pad;
    btn_debounce_ev #(.BTN_WIDTH(W), .DEB_CYCLES(20'(DEB)), .LONG_CYCLES(32'(LONG)),
        .REPEAT_CYCLES(32'(REP)), .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b1))
        dut_a (.sys_clk(sys_clk), .rst_n(rst_n), .bus(bus_a));
    btn_debounce_ev #(.BTN_WIDTH(W), .DEB_CYCLES(20'(DEB)), .LONG_CYCLES(32'(LONG)),
        .REPEAT_CYCLES(32'(REP)), .REPEAT_EN(1'b0), .ACTIVE_LOW(1'b1))
        dut_b (.sys_clk(sys_clk), .rst_n(rst_n), .bus(bus_b));
    int n_chk = 0, n_fail = 0, cyc = 0;
    logic [W-1:0] pad_d1, pad_d2, e_stable, e_press, e_rel, e_long, e_rep;
    logic [DEB-1:0] win [W];
    int t_press [W];
    int c_press_a [W], c_rel_a [W], c_long_a [W], c_rep_a [W];
    int c_press_b [W], c_rel_b [W], c_long_b [W], c_rep_b [W];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask
    // Reference: level accepted once the last DEB synchronised samples all oppose it;
    // long/repeat derived from elapsed time since the press timestamp.
    task automatic model_step();
        logic [W-1:0] ps;
        cyc++;
        e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
        if (!rst_n) begin
            pad_d1 = '1; pad_d2 = '1; e_stable = '0;
            for (int c = 0; c < W; c++) win[c] = '0;
            return;
        end
        ps = ~pad_d2;
        pad_d2 = pad_d1;
        pad_d1 = pad;
        for (int c = 0; c < W; c++) begin
            win[c] = {win[c][DEB-2:0], ps[c]};
            if (win[c] == {DEB{~e_stable[c]}}) begin
                e_stable[c] = ~e_stable[c];
                if (e_stable[c]) begin
                    e_press[c] = 1'b1;
                    t_press[c] = cyc;
                end else e_rel[c] = 1'b1;
            end
            if (e_stable[c]) begin
                int d;
                d = cyc - t_press[c];
                e_long[c] = d == LONG;
                e_rep[c]  = d > LONG && (d - LONG) % REP == 0;
            end
        end
    endtask
    task automatic clr_counts();
        for (int c = 0; c < W; c++) begin
            c_press_a[c] = 0; c_rel_a[c] = 0; c_long_a[c] = 0; c_rep_a[c] = 0;
            c_press_b[c] = 0; c_rel_b[c] = 0; c_long_b[c] = 0; c_rep_b[c] = 0;
        end
    endtask
    task automatic tick();
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
        check("stable_a", bus_a.btn_stable, e_stable);
        check("press_a", bus_a.btn_press, e_press);
        check("release_a", bus_a.btn_release, e_rel);
        check("long_a", bus_a.btn_long, e_long);
        check("repeat_a", bus_a.btn_repeat, e_rep);
        check("stable_b", bus_b.btn_stable, e_stable);
        check("press_b", bus_b.btn_press, e_press);
        check("release_b", bus_b.btn_release, e_rel);
        check("long_b", bus_b.btn_long, e_long);
        check("repeat_b", bus_b.btn_repeat, '0);
        for (int c = 0; c < W; c++) begin
            c_press_a[c] += int'(bus_a.btn_press[c]);
            c_rel_a[c]   += int'(bus_a.btn_release[c]);
            c_long_a[c]  += int'(bus_a.btn_long[c]);
            c_rep_a[c]   += int'(bus_a.btn_repeat[c]);
            c_press_b[c] += int'(bus_b.btn_press[c]);
            c_rel_b[c]   += int'(bus_b.btn_release[c]);
            c_long_b[c]  += int'(bus_b.btn_long[c]);
            c_rep_b[c]   += int'(bus_b.btn_repeat[c]);
        end
    endtask
    task automatic run(input int n);
        repeat (n) tick();
    endtask
    initial begin
        int pulses;
        int rate [W];
        clr_counts();
        run(3);
        rst_n = 1'b1;
        run(100);
        pulses = 0;
        for (int c = 0; c < W; c++) pulses += c_press_a[c] + c_rel_a[c] + c_long_a[c] + c_rep_a[c];
        check("idle_pulses", 32'(pulses), 0);
        clr_counts();
        pad[0] = 1'b0;
        run(5);
        check("ch0_before", {31'd0, bus_a.btn_stable[0]}, 0);
        run(1);
        check("ch0_press", {31'd0, bus_a.btn_press[0]}, 1);
        run(1);
        check("ch0_press_low", {31'd0, bus_a.btn_press[0]}, 0);
        run(25);
        pad[0] = 1'b1;
        run(20);
        check("ch0_others", 32'(c_press_a[1] + c_press_a[7]), 0);
        clr_counts();
        pad[1] = 1'b0; run(3);
        pad[1] = 1'b1; run(2);
        pad[1] = 1'b0; run(3);
        pad[1] = 1'b1; run(20);
        check("ch1_bounce", 32'(c_press_a[1] + c_rel_a[1]), 0);
        clr_counts();
        pad[2] = 1'b0; run(60);
        pad[2] = 1'b1; run(30);
        check("ch2_long", 32'(c_long_a[2]), 1);
        check("ch2_repeats", 32'(c_rep_a[2]), 4);
        check("ch2_release", 32'(c_rel_a[2]), 1);
        clr_counts();
        pad[3] = 1'b0; run(40);
        pad[3] = 1'b1; run(20);
        check("ch3_long_b", 32'(c_long_b[3]), 1);
        check("ch3_rep_b", 32'(c_rep_b[3]), 0);
        clr_counts();
        pad[3] = 1'b0; run(10);
        pad[3] = 1'b1; run(20);
        check("ch3_short_evts", 32'(c_press_b[3] + c_rel_b[3]), 2);
        check("ch3_short_long", 32'(c_long_b[3]), 0);
        clr_counts();
        pad[5:4] = 2'b00; run(15);
        rst_n = 1'b0; run(3);
        check("rst_outputs", {24'd0, bus_a.btn_stable}, 0);
        rst_n = 1'b1; run(30);
        check("ch4_no_release", 32'(c_rel_a[4] + c_rel_a[5]), 0);
        check("ch45_repress", 32'(c_press_a[4] + c_press_a[5]), 4);
        pad[5:4] = 2'b11; run(20);
        for (int c = 0; c < W; c++) rate[c] = (c % 3 == 0) ? 2 : (c % 3 == 1) ? 8 : 30;
        repeat (4000) begin
            for (int c = 0; c < W; c++)
                if ($urandom_range(0, 99) < rate[c]) pad[c] = ~pad[c];
            rst_n = ($urandom_range(0, 599) != 0);
            tick();
        end
        rst_n = 1'b1;
        run(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
